// File: rtl/mag_cmp_sweeper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_cmp_sweeper_pkg                                                  |
// | Shared sweeper state encoding and golden comparator relation.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mag_cmp_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Expected {equal, greater, lower}; operands are zero-extended and unsigned.
    function automatic logic [2:0] rel(input logic [7:0] a, input logic [7:0] b);
        rel = {a == b, a > b, a < b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mag_cmp_golden.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_cmp_golden                                                       |
// | Combinational reference flags for an unsigned magnitude comparator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mag_cmp_golden #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_equal,
    output logic             o_greater,
    output logic             o_lower
);
    import mag_cmp_sweeper_pkg::*;

    logic [2:0] w_rel;

    assign w_rel = rel(8'(i_a), 8'(i_b));
    assign {o_equal, o_greater, o_lower} = w_rel;

endmodule
`default_nettype wire

// File: rtl/mag_cmp_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_cmp_sweeper                                                      |
// | Exhaustive operand sweep and flag checker for a magnitude comparator.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mag_cmp_sweeper #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             equal,
    input  logic             greater,
    input  logic             lower,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);
    import mag_cmp_sweeper_pkg::*;

    localparam int                  c_IDX_W     = 2 * WIDTH;
    localparam int                  c_WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(SETTLE - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_WAIT_W-1:0]  r_wait;
    logic                 r_busy;
    logic                 r_done;
    logic [ERR_W-1:0]     r_err;
    logic                 r_fail_valid;
    logic [WIDTH-1:0]     r_fail_a;
    logic [WIDTH-1:0]     r_fail_b;

    logic                 w_accept;
    logic                 w_vec_fail;
    logic                 w_last;
    logic                 w_exp_eq;
    logic                 w_exp_gt;
    logic                 w_exp_lt;

    // Operand A is the major half of the sweep index, B the minor half.
    assign a = r_idx[c_IDX_W-1:WIDTH];
    assign b = r_idx[WIDTH-1:0];

    mag_cmp_golden #(
        .WIDTH     (WIDTH)
    ) u_golden (
        .i_a       (a),
        .i_b       (b),
        .o_equal   (w_exp_eq),
        .o_greater (w_exp_gt),
        .o_lower   (w_exp_lt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_vec_fail  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_vec_fail  = ({equal, greater, lower} != {w_exp_eq, w_exp_gt, w_exp_lt});
                w_last      = &r_idx;
                w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else begin
            if (w_accept) begin
                r_idx        <= '0;
                r_wait       <= '0;
                r_err        <= '0;
                r_fail_valid <= 1'b0;
                r_fail_a     <= '0;
                r_fail_b     <= '0;
                r_done       <= 1'b0;
                r_busy       <= 1'b1;
            end
            if (r_state == ST_SETTLE) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_state == ST_CHECK) begin
                if (w_vec_fail) begin
                    if (r_err != {ERR_W{1'b1}}) begin
                        r_err <= r_err + 1'b1;
                    end
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_a     <= a;
                        r_fail_b     <= b;
                    end
                end
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx  <= r_idx + 1'b1;
                    r_wait <= '0;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_done && (r_err == '0);
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;

endmodule
`default_nettype wire
